// File: rtl/axi_sub_arb.sv
// Per-burst round-robin arbiter sharing one component port between the AXI write
// and read subordinates; the granted beat passes straight through with no added latency.
module axi_sub_arb #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned UW = 32,
  parameter int unsigned IW = 1,
  localparam int unsigned BC = DW / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  // write requester
  input  logic          w_dv,
  input  logic [AW-1:0] w_addr,
  input  logic [UW-1:0] w_user,
  input  logic [IW-1:0] w_id,
  input  logic [DW-1:0] w_wdata,
  input  logic [BC-1:0] w_wstrb,
  input  logic          w_last,
  output logic          w_hld,
  output logic          w_err,
  // read requester
  input  logic          r_dv,
  input  logic [AW-1:0] r_addr,
  input  logic [UW-1:0] r_user,
  input  logic [IW-1:0] r_id,
  input  logic          r_last,
  output logic          r_hld,
  output logic          r_err,
  output logic [DW-1:0] r_rdata,
  // component port
  output logic          dv,
  output logic          write,
  output logic [AW-1:0] addr,
  output logic [UW-1:0] user,
  output logic [IW-1:0] id,
  output logic [DW-1:0] wdata,
  output logic [BC-1:0] wstrb,
  output logic          last,
  input  logic          hld,
  input  logic          err,
  input  logic [DW-1:0] rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_LOCK = 2'd1,
    S_RD_LOCK = 2'd2
  } state_t;

  state_t r_state;
  logic   r_pri;      // 0: write wins next contention, 1: read wins
  logic   w_gnt_wr;
  logic   w_gnt_rd;
  logic   w_accept;

  // Grant select; nothing is selected while reset is asserted
  always_comb begin
    w_gnt_wr = 1'b0;
    w_gnt_rd = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (w_dv && r_dv) begin
            w_gnt_wr = ~r_pri;
            w_gnt_rd = r_pri;
          end else begin
            w_gnt_wr = w_dv;
            w_gnt_rd = r_dv;
          end
        end
        S_WR_LOCK: w_gnt_wr = 1'b1;
        S_RD_LOCK: w_gnt_rd = 1'b1;
        default: begin
          w_gnt_wr = 1'b0;
          w_gnt_rd = 1'b0;
        end
      endcase
    end
  end

  // Component-side mux: the selected requester's beat, zeros otherwise
  always_comb begin
    dv    = 1'b0;
    write = 1'b0;
    addr  = '0;
    user  = '0;
    id    = '0;
    wdata = '0;
    wstrb = '0;
    last  = 1'b0;
    if (w_gnt_wr) begin
      dv    = w_dv;
      write = 1'b1;
      addr  = w_addr;
      user  = w_user;
      id    = w_id;
      wdata = w_wdata;
      wstrb = w_wstrb;
      last  = w_last;
    end else if (w_gnt_rd) begin
      dv    = r_dv;
      addr  = r_addr;
      user  = r_user;
      id    = r_id;
      last  = r_last;
    end
  end

  // Requester-side returns: the loser is always stalled and never sees an error
  always_comb begin
    w_hld = 1'b1;
    w_err = 1'b0;
    r_hld = 1'b1;
    r_err = 1'b0;
    if (w_gnt_wr) begin
      w_hld = hld;
      w_err = err;
    end
    if (w_gnt_rd) begin
      r_hld = hld;
      r_err = err;
    end
  end

  assign r_rdata  = rdata;
  assign w_accept = dv & ~hld;
  assign busy     = (r_state != S_IDLE);

  // Burst lock and round-robin priority; pri flips toward the loser on each accepted last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pri   <= 1'b0;
    end else if (w_accept) begin
      if (last) begin
        r_state <= S_IDLE;
        r_pri   <= w_gnt_wr;
      end else if (r_state == S_IDLE) begin
        r_state <= w_gnt_wr ? S_WR_LOCK : S_RD_LOCK;
      end
    end
  end

  a_one_source: assert property (@(posedge clk) disable iff (!rst_n)
    dv |-> (w_gnt_wr ^ w_gnt_rd));

  a_wr_lock_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_WR_LOCK) && !(w_accept && last) |=> (r_state == S_WR_LOCK));

  a_rd_lock_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == S_RD_LOCK) && !(w_accept && last) |=> (r_state == S_RD_LOCK));

  a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({dv, hld, w_hld, r_hld}));

endmodule

// File: tb/tb_axi_sub_arb.sv
// Directed bench for axi_sub_arb: burst locking, round-robin, stalls, errors and reset.
module tb_axi_sub_arb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned UW = 32;
  localparam int unsigned IW = 1;
  localparam int unsigned BC = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          w_dv, w_last, w_hld, w_err;
  logic [AW-1:0] w_addr;
  logic [UW-1:0] w_user;
  logic [IW-1:0] w_id;
  logic [DW-1:0] w_wdata;
  logic [BC-1:0] w_wstrb;
  logic          r_dv, r_last, r_hld, r_err;
  logic [AW-1:0] r_addr;
  logic [UW-1:0] r_user;
  logic [IW-1:0] r_id;
  logic [DW-1:0] r_rdata;
  logic          dv, write, last, hld, err, busy;
  logic [AW-1:0] addr;
  logic [UW-1:0] user;
  logic [IW-1:0] id;
  logic [DW-1:0] wdata, rdata;
  logic [BC-1:0] wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_sub_arb #(.AW(AW), .DW(DW), .UW(UW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .w_dv(w_dv), .w_addr(w_addr), .w_user(w_user), .w_id(w_id), .w_wdata(w_wdata),
    .w_wstrb(w_wstrb), .w_last(w_last), .w_hld(w_hld), .w_err(w_err),
    .r_dv(r_dv), .r_addr(r_addr), .r_user(r_user), .r_id(r_id), .r_last(r_last),
    .r_hld(r_hld), .r_err(r_err), .r_rdata(r_rdata),
    .dv(dv), .write(write), .addr(addr), .user(user), .id(id), .wdata(wdata),
    .wstrb(wstrb), .last(last), .hld(hld), .err(err), .rdata(rdata), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_dv = 1'b0; w_addr = '0; w_user = '0; w_id = '0; w_wdata = '0; w_wstrb = '0; w_last = 1'b0;
    r_dv = 1'b0; r_addr = '0; r_user = '0; r_id = '0; r_last = 1'b0;
    hld = 1'b0; err = 1'b0; rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0; w_dv = 1'b1; r_dv = 1'b1;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (w_hld !== 1'b1) begin n_bad++; $display("FAIL rst_w_hld got %b exp 1", w_hld); end
    n_cmp++; if (r_hld !== 1'b1) begin n_bad++; $display("FAIL rst_r_hld got %b exp 1", r_hld); end
    n_cmp++; if (dv !== 1'b0) begin n_bad++; $display("FAIL rst_dv got %b exp 0", dv); end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_only();
    for (int i = 0; i < 4; i++) begin
      w_dv = 1'b1; w_addr = 32'h100 + 32'(4 * i); w_wdata = 32'hD000 + 32'(i);
      w_wstrb = 4'hF; w_last = (i == 3);
      #2;
      n_cmp++; if (dv !== 1'b1) begin n_bad++; $display("FAIL wo_dv beat%0d got %b exp 1", i, dv); end
      n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL wo_write beat%0d got %b exp 1", i, write); end
      n_cmp++; if (addr !== 32'h100 + 32'(4 * i)) begin n_bad++; $display("FAIL wo_addr beat%0d got %h exp %h", i, addr, 32'h100 + 32'(4 * i)); end
      n_cmp++; if (wdata !== 32'hD000 + 32'(i)) begin n_bad++; $display("FAIL wo_wdata beat%0d got %h", i, wdata); end
      n_cmp++; if (last !== (i == 3)) begin n_bad++; $display("FAIL wo_last beat%0d got %b", i, last); end
      n_cmp++; if (w_hld !== 1'b0) begin n_bad++; $display("FAIL wo_w_hld beat%0d got %b exp 0", i, w_hld); end
      n_cmp++; if (r_hld !== 1'b1) begin n_bad++; $display("FAIL wo_r_hld beat%0d got %b exp 1", i, r_hld); end
      n_cmp++; if (busy !== (i != 0)) begin n_bad++; $display("FAIL wo_busy beat%0d got %b exp %b", i, busy, i != 0); end
      tick();
    end
    idle_inputs();
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wo_busy_end got %b exp 0", busy); end
    n_cmp++; if (dv !== 1'b0) begin n_bad++; $display("FAIL wo_dv_end got %b exp 0", dv); end
    n_cmp++; if (dut.r_pri !== 1'b1) begin n_bad++; $display("FAIL wo_pri got %b exp 1", dut.r_pri); end
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    w_dv = 1'b1; w_last = 1'b0; w_wstrb = 4'hA; r_dv = 1'b1; r_last = 1'b0;
    #2;
    n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL ct_first_write got %b exp 1", write); end
    n_cmp++; if (w_hld !== 1'b0) begin n_bad++; $display("FAIL ct_first_w_hld got %b exp 0", w_hld); end
    n_cmp++; if (r_hld !== 1'b1) begin n_bad++; $display("FAIL ct_first_r_hld got %b exp 1", r_hld); end
    tick();
    w_last = 1'b1;
    #2;
    n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL ct_wlast_write got %b exp 1", write); end
    n_cmp++; if (r_hld !== 1'b1) begin n_bad++; $display("FAIL ct_wlast_r_hld got %b exp 1", r_hld); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ct_wlast_busy got %b exp 1", busy); end
    tick();
    #2;
    n_cmp++; if (write !== 1'b0) begin n_bad++; $display("FAIL ct_second_write got %b exp 0", write); end
    n_cmp++; if (r_hld !== 1'b0) begin n_bad++; $display("FAIL ct_second_r_hld got %b exp 0", r_hld); end
    n_cmp++; if (w_hld !== 1'b1) begin n_bad++; $display("FAIL ct_second_w_hld got %b exp 1", w_hld); end
    n_cmp++; if (wstrb !== 4'h0) begin n_bad++; $display("FAIL ct_read_wstrb got %h exp 0", wstrb); end
    tick();
    r_last = 1'b1;
    #2;
    n_cmp++; if (w_hld !== 1'b1) begin n_bad++; $display("FAIL ct_rlast_w_hld got %b exp 1", w_hld); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL ct_rlast_busy got %b exp 1", busy); end
    tick();
    #2;
    n_cmp++; if (write !== 1'b1) begin n_bad++; $display("FAIL ct_third_write got %b exp 1", write); end
    n_cmp++; if (r_hld !== 1'b1) begin n_bad++; $display("FAIL ct_third_r_hld got %b exp 1", r_hld); end
    tick();
    idle_inputs();
  endtask

  task automatic test_read_stall();
    r_dv = 1'b1; r_addr = 32'h200; r_last = 1'b0;
    #2;
    n_cmp++; if (dv !== 1'b1 || write !== 1'b0) begin n_bad++; $display("FAIL rs_b0 got dv=%b write=%b exp 1/0", dv, write); end
    n_cmp++; if (r_hld !== 1'b0) begin n_bad++; $display("FAIL rs_b0_r_hld got %b exp 0", r_hld); end
    tick();
    r_addr = 32'h204; w_dv = 1'b1; w_last = 1'b1; hld = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      n_cmp++; if (r_hld !== 1'b1) begin n_bad++; $display("FAIL rs_stall%0d_r_hld got %b exp 1", c, r_hld); end
      n_cmp++; if (w_hld !== 1'b1) begin n_bad++; $display("FAIL rs_stall%0d_w_hld got %b exp 1", c, w_hld); end
      n_cmp++; if (addr !== 32'h204 || write !== 1'b0) begin n_bad++; $display("FAIL rs_stall%0d_beat got addr=%h write=%b exp 204/0", c, addr, write); end
      tick();
    end
    hld = 1'b0;
    #2;
    n_cmp++; if (r_hld !== 1'b0) begin n_bad++; $display("FAIL rs_b1_r_hld got %b exp 0", r_hld); end
    n_cmp++; if (w_hld !== 1'b1) begin n_bad++; $display("FAIL rs_b1_w_hld got %b exp 1", w_hld); end
    tick();
    r_addr = 32'h208; r_last = 1'b1;
    #2;
    n_cmp++; if (addr !== 32'h208 || last !== 1'b1) begin n_bad++; $display("FAIL rs_b2 got addr=%h last=%b exp 208/1", addr, last); end
    n_cmp++; if (w_hld !== 1'b1) begin n_bad++; $display("FAIL rs_b2_w_hld got %b exp 1", w_hld); end
    tick();
    r_dv = 1'b0; r_last = 1'b0;
    #2;
    n_cmp++; if (w_hld !== 1'b0 || write !== 1'b1) begin n_bad++; $display("FAIL rs_after got w_hld=%b write=%b exp 0/1", w_hld, write); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rs_after_busy got %b exp 0", busy); end
    tick();
    idle_inputs();
  endtask

  task automatic test_drop_dv();
    w_dv = 1'b1; w_last = 1'b0;
    #2;
    n_cmp++; if (write !== 1'b1 || dv !== 1'b1) begin n_bad++; $display("FAIL dd_b0 got dv=%b write=%b exp 1/1", dv, write); end
    tick();
    w_dv = 1'b0; r_dv = 1'b1; r_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      n_cmp++; if (dv !== 1'b0) begin n_bad++; $display("FAIL dd_gap%0d_dv got %b exp 0", c, dv); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL dd_gap%0d_busy got %b exp 1", c, busy); end
      n_cmp++; if (r_hld !== 1'b1) begin n_bad++; $display("FAIL dd_gap%0d_r_hld got %b exp 1", c, r_hld); end
      tick();
    end
    w_dv = 1'b1; w_last = 1'b1;
    #2;
    n_cmp++; if (dv !== 1'b1 || write !== 1'b1) begin n_bad++; $display("FAIL dd_resume got dv=%b write=%b exp 1/1", dv, write); end
    n_cmp++; if (r_hld !== 1'b1) begin n_bad++; $display("FAIL dd_resume_r_hld got %b exp 1", r_hld); end
    tick();
    w_dv = 1'b0; w_last = 1'b0;
    #2;
    n_cmp++; if (r_hld !== 1'b0 || write !== 1'b0) begin n_bad++; $display("FAIL dd_read got r_hld=%b write=%b exp 0/0", r_hld, write); end
    tick();
    idle_inputs();
  endtask

  task automatic test_err_rdata();
    w_dv = 1'b1; w_last = 1'b0; r_dv = 1'b1; r_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      err = (i == 1); w_last = (i == 2);
      #2;
      n_cmp++; if (w_err !== (i == 1)) begin n_bad++; $display("FAIL er_w_err beat%0d got %b exp %b", i, w_err, i == 1); end
      n_cmp++; if (r_err !== 1'b0) begin n_bad++; $display("FAIL er_r_err beat%0d got %b exp 0", i, r_err); end
      tick();
    end
    err = 1'b0; w_dv = 1'b0; w_last = 1'b0; rdata = 32'hA5A5A5A5;
    #2;
    n_cmp++; if (r_rdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL er_rdata got %h exp a5a5a5a5", r_rdata); end
    n_cmp++; if (r_hld !== 1'b0 || dv !== 1'b1 || write !== 1'b0) begin n_bad++; $display("FAIL er_read_beat got r_hld=%b dv=%b write=%b exp 0/1/0", r_hld, dv, write); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_midburst();
    w_dv = 1'b1; w_last = 1'b1;
    tick();
    idle_inputs();
    #2;
    n_cmp++; if (dut.r_pri !== 1'b1) begin n_bad++; $display("FAIL rm_pre_pri got %b exp 1", dut.r_pri); end
    r_dv = 1'b1; r_last = 1'b0;
    tick();
    #2;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rm_lock_busy got %b exp 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy got %b exp 0", busy); end
    n_cmp++; if (dut.r_pri !== 1'b0) begin n_bad++; $display("FAIL rm_pri got %b exp 0", dut.r_pri); end
    n_cmp++; if (dv !== 1'b0) begin n_bad++; $display("FAIL rm_dv got %b exp 0", dv); end
    n_cmp++; if (r_hld !== 1'b1 || w_hld !== 1'b1) begin n_bad++; $display("FAIL rm_hld got r=%b w=%b exp 1/1", r_hld, w_hld); end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    w_dv = 1'b1; w_last = 1'b1; r_dv = 1'b1; r_last = 1'b1;
    #2;
    n_cmp++; if (write !== 1'b1 || w_hld !== 1'b0) begin n_bad++; $display("FAIL rm_post got write=%b w_hld=%b exp 1/0", write, w_hld); end
    n_cmp++; if (r_hld !== 1'b1) begin n_bad++; $display("FAIL rm_post_r_hld got %b exp 1", r_hld); end
    tick();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_only();
    test_contention();
    test_read_stall();
    test_drop_dv();
    test_err_rdata();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
